// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU register-file sequencer: widths, opcodes,
// controller states and instruction field positions.
package cpu_pkg;

  localparam int DATA_W     = 8;
  localparam int REG_ADDR_W = 3;
  localparam int INSTR_W    = 16;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LDI = 4'd1;
  localparam logic [3:0] OP_MOV = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_DECODE    = 2'd1,
    S_EXECUTE   = 2'd2,
    S_WRITEBACK = 2'd3
  } state_t;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS1_MSB = 8;
  localparam int RS1_LSB = 6;
  localparam int RS2_MSB = 5;
  localparam int RS2_LSB = 3;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  // LDI through SHR produce a register write; NOP, CMP and illegal do not.
  function automatic logic writesReg(input logic [3:0] op);
    return (op >= OP_LDI) && (op <= OP_SHR);
  endfunction

  // Everything above CMP is an undefined opcode.
  function automatic logic isIllegal(input logic [3:0] op);
    return op > OP_CMP;
  endfunction

endpackage

// File: rtl/regfile_sequencer_if.sv
// Instruction handshake plus register-file read/write bus of the sequencer.
// The slave side is the sequencer; the master side is the instruction
// source together with the register file it controls.
interface regfile_sequencer_if;
  import cpu_pkg::*;

  logic                  instr_valid;
  logic [INSTR_W-1:0]    instr;
  logic                  instr_ready;
  logic [REG_ADDR_W-1:0] rs1_ptr;
  logic [REG_ADDR_W-1:0] rs2_ptr;
  logic [DATA_W-1:0]     rs1_data;
  logic [DATA_W-1:0]     rs2_data;
  logic                  reg_write;
  logic [REG_ADDR_W-1:0] rd_ptr;
  logic [DATA_W-1:0]     wb_data;
  logic                  flag_z;
  logic                  flag_c;
  logic                  illegal;
  logic                  busy;

  modport slave (
    input  instr_valid, instr, rs1_data, rs2_data,
    output instr_ready, rs1_ptr, rs2_ptr, reg_write, rd_ptr, wb_data,
           flag_z, flag_c, illegal, busy
  );

  modport master (
    output instr_valid, instr, rs1_data, rs2_data,
    input  instr_ready, rs1_ptr, rs2_ptr, reg_write, rd_ptr, wb_data,
           flag_z, flag_c, illegal, busy
  );

endinterface

// File: rtl/regfile_sequencer_alu8.sv
// Combinational 8-bit ALU used in the EXECUTE step. Besides the result it
// reports the candidate flags and whether this opcode is allowed to update them.
module alu8
  import cpu_pkg::*;
(
  input  logic [3:0]        opcode_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] imm8_i,
  output logic [DATA_W-1:0] result_o,
  output logic              c_out_o,
  output logic              z_out_o,
  output logic              flag_update_o
);

  logic [DATA_W:0] sum9;
  logic [DATA_W:0] diff9;

  // Result, carry/borrow and flag-update qualifier per opcode; the top bit of
  // the 9-bit difference is the unsigned borrow used by SUB and CMP.
  always_comb begin
    sum9          = {1'b0, a_i} + {1'b0, b_i};
    diff9         = {1'b0, a_i} - {1'b0, b_i};
    result_o      = '0;
    c_out_o       = 1'b0;
    flag_update_o = 1'b0;
    case (opcode_i)
      OP_NOP: result_o = '0;
      OP_LDI: result_o = imm8_i;
      OP_MOV: result_o = a_i;
      OP_ADD: begin
        result_o      = sum9[DATA_W-1:0];
        c_out_o       = sum9[DATA_W];
        flag_update_o = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        result_o      = diff9[DATA_W-1:0];
        c_out_o       = diff9[DATA_W];
        flag_update_o = 1'b1;
      end
      OP_AND: begin
        result_o      = a_i & b_i;
        flag_update_o = 1'b1;
      end
      OP_OR: begin
        result_o      = a_i | b_i;
        flag_update_o = 1'b1;
      end
      OP_XOR: begin
        result_o      = a_i ^ b_i;
        flag_update_o = 1'b1;
      end
      OP_SHL: begin
        result_o      = {a_i[DATA_W-2:0], 1'b0};
        c_out_o       = a_i[DATA_W-1];
        flag_update_o = 1'b1;
      end
      OP_SHR: begin
        result_o      = {1'b0, a_i[DATA_W-1:1]};
        c_out_o       = a_i[0];
        flag_update_o = 1'b1;
      end
      default: result_o = '0;
    endcase
    z_out_o = (result_o == '0);
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Operand-fetch and write-back controller for the 8x8 register file. Each
// accepted instruction walks IDLE -> DECODE -> EXECUTE -> WRITEBACK and
// produces at most one registered write strobe.
module regfile_sequencer
  import cpu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  regfile_sequencer_if.slave bus
);

  state_t                state_q, state_d;
  logic [INSTR_W-1:0]    ir_q;
  logic [DATA_W-1:0]     opA_q, opB_q;
  logic                  regWrite_q;
  logic [REG_ADDR_W-1:0] rdPtr_q;
  logic [DATA_W-1:0]     wbData_q;
  logic                  flagZ_q, flagC_q;
  logic                  illegal_q;
  logic                  instrReady;
  logic                  handshake;

  logic [3:0]            opcode;
  logic [DATA_W-1:0]     aluResult;
  logic                  aluC, aluZ, aluFlagUpdate;

  assign opcode = ir_q[OPC_MSB:OPC_LSB];

  alu8 uAlu (
    .opcode_i      (opcode),
    .a_i           (opA_q),
    .b_i           (opB_q),
    .imm8_i        (ir_q[IMM_MSB:IMM_LSB]),
    .result_o      (aluResult),
    .c_out_o       (aluC),
    .z_out_o       (aluZ),
    .flag_update_o (aluFlagUpdate)
  );

  // Next state and handshake; ready is withheld while reset is asserted so
  // reset always wins over a simultaneous transfer.
  always_comb begin
    state_d    = state_q;
    instrReady = (state_q == S_IDLE) && !rst;
    handshake  = instrReady && bus.instr_valid;
    case (state_q)
      S_IDLE:      if (handshake) state_d = S_DECODE;
      S_DECODE:    state_d = S_EXECUTE;
      S_EXECUTE:   state_d = S_WRITEBACK;
      S_WRITEBACK: state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Instruction register and operand latches; operands are sampled from the
  // register file at the end of DECODE while the read pointers are stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q  <= '0;
      opA_q <= '0;
      opB_q <= '0;
    end else begin
      if (handshake) ir_q <= bus.instr;
      if (state_q == S_DECODE) begin
        opA_q <= bus.rs1_data;
        opB_q <= bus.rs2_data;
      end
    end
  end

  // Write-back and flag registers, loaded at the end of EXECUTE so the write
  // strobe and the illegal pulse live exactly in the WRITEBACK cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      regWrite_q <= 1'b0;
      rdPtr_q    <= '0;
      wbData_q   <= '0;
      flagZ_q    <= 1'b0;
      flagC_q    <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      regWrite_q <= 1'b0;
      illegal_q  <= 1'b0;
      if (state_q == S_EXECUTE) begin
        regWrite_q <= writesReg(opcode);
        illegal_q  <= isIllegal(opcode);
        if (writesReg(opcode)) begin
          rdPtr_q  <= ir_q[RD_MSB:RD_LSB];
          wbData_q <= aluResult;
        end
        if (aluFlagUpdate) begin
          flagZ_q <= aluZ;
          flagC_q <= aluC;
        end
      end
    end
  end

  assign bus.instr_ready = instrReady;
  assign bus.busy        = !instrReady;
  assign bus.rs1_ptr     = ir_q[RS1_MSB:RS1_LSB];
  assign bus.rs2_ptr     = ir_q[RS2_MSB:RS2_LSB];
  assign bus.reg_write   = regWrite_q;
  assign bus.rd_ptr      = rdPtr_q;
  assign bus.wb_data     = wbData_q;
  assign bus.flag_z      = flagZ_q;
  assign bus.flag_c      = flagC_q;
  assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Scoreboard bench for regfile_sequencer: a behavioural register file is
// attached to the read/write bus, a reference model predicts each
// instruction's outcome and a monitor checks every retired instruction.
module tb_regfile_sequencer;

  typedef struct {
    bit doWrite;
    int rd;
    int data;
    bit z;
    bit c;
    bit ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  regfile_sequencer_if bus();

  regfile_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural register file driven only by the DUT's write port.
  logic [7:0] rf [8];
  assign bus.rs1_data = rf[bus.rs1_ptr];
  assign bus.rs2_data = rf[bus.rs2_ptr];

  always @(posedge clk) begin
    if (bus.reg_write) rf[bus.rd_ptr] <= bus.wb_data;
  end

  int   checks = 0;
  int   errors = 0;
  exp_t sbQ[$];

  int regModel [8];
  bit zModel = 1'b0;
  bit cModel = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Reference model: architectural effect of one instruction on the
  // register array and flags, computed with plain integer arithmetic.
  task automatic predict(input logic [15:0] ins, output exp_t e);
    int op, a, b, imm, res;
    bit c, upd;
    op  = int'(ins[15:12]);
    a   = regModel[ins[8:6]];
    b   = regModel[ins[5:3]];
    imm = int'(ins[7:0]);
    res = 0;
    c   = 1'b0;
    upd = 1'b0;
    e.doWrite = 1'b0;
    e.ill     = 1'b0;
    e.rd      = int'(ins[11:9]);
    case (op)
      0: ;
      1: begin res = imm; e.doWrite = 1'b1; end
      2: begin res = a;   e.doWrite = 1'b1; end
      3: begin res = a + b; c = (res > 255); res = res % 256; upd = 1'b1; e.doWrite = 1'b1; end
      4: begin c = (a < b); res = (a - b + 256) % 256; upd = 1'b1; e.doWrite = 1'b1; end
      5: begin res = a & b; upd = 1'b1; e.doWrite = 1'b1; end
      6: begin res = a | b; upd = 1'b1; e.doWrite = 1'b1; end
      7: begin res = a ^ b; upd = 1'b1; e.doWrite = 1'b1; end
      8: begin c = (a >= 128); res = (a * 2) % 256; upd = 1'b1; e.doWrite = 1'b1; end
      9: begin c = (a % 2 == 1); res = a / 2; upd = 1'b1; e.doWrite = 1'b1; end
      10: begin c = (a < b); res = (a - b + 256) % 256; upd = 1'b1; end
      default: e.ill = 1'b1;
    endcase
    if (upd) begin
      zModel = (res == 0);
      cModel = c;
    end
    if (e.doWrite) regModel[e.rd] = res;
    e.data = res;
    e.z    = zModel;
    e.c    = cModel;
  endtask

  function automatic logic [15:0] enc(input int op, input int rd, input int rs1, input int rs2);
    logic [3:0] o;
    logic [2:0] d, s1, s2;
    o = op[3:0]; d = rd[2:0]; s1 = rs1[2:0]; s2 = rs2[2:0];
    return {o, d, s1, s2, 3'b000};
  endfunction

  function automatic logic [15:0] encLdi(input int rd, input int imm);
    logic [2:0] d;
    logic [7:0] i8;
    d = rd[2:0]; i8 = imm[7:0];
    return {4'd1, d, 1'b0, i8};
  endfunction

  // Monitor: tracks one busy period and compares it against the scoreboard
  // entry when the sequencer becomes ready again.
  int busyCycles = 0;
  int wrCount    = 0;
  int wrCycle    = 0;
  int wrRd       = 0;
  int wrData     = 0;
  int illCount   = 0;
  bit inFlight   = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      inFlight = 1'b0; busyCycles = 0; wrCount = 0; wrCycle = 0; illCount = 0;
    end else if (!bus.instr_ready) begin
      inFlight = 1'b1;
      busyCycles++;
      if (bus.reg_write) begin
        wrCount++;
        wrCycle = busyCycles;
        wrRd    = int'(bus.rd_ptr);
        wrData  = int'(bus.wb_data);
      end
      if (bus.illegal) illCount++;
    end else if (inFlight) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedRetire", 1, 0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("busyCycles", busyCycles, 3);
        checkOutput("writeCount", wrCount, e.doWrite ? 1 : 0);
        if (e.doWrite) begin
          checkOutput("writeLatency", wrCycle, 3);
          checkOutput("rdPtr", wrRd, e.rd);
          checkOutput("wbData", wrData, e.data);
        end
        checkOutput("illegalPulses", illCount, e.ill ? 1 : 0);
        checkOutput("flagZ", int'(bus.flag_z), int'(e.z));
        checkOutput("flagC", int'(bus.flag_c), int'(e.c));
      end
      inFlight = 1'b0; busyCycles = 0; wrCount = 0; wrCycle = 0; illCount = 0;
    end
  end

  task automatic waitReady();
    int n = 0;
    while (!bus.instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.instr_ready) checkOutput("readyTimeout", 0, 1);
  endtask

  // Offers one instruction for a single cycle once the sequencer is idle.
  task automatic applyStimulus(input logic [15:0] ins);
    exp_t e;
    waitReady();
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    predict(ins, e);
    sbQ.push_back(e);
    @(negedge clk);
    bus.instr_valid = 1'b0;
  endtask

  // Holds instr_valid for eight cycles; only two transfers may happen.
  task automatic applyHeld(input logic [15:0] ins);
    exp_t e;
    int accepted = 0;
    waitReady();
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    repeat (8) begin
      if (bus.instr_ready) begin
        predict(ins, e);
        sbQ.push_back(e);
        accepted++;
      end
      @(negedge clk);
    end
    bus.instr_valid = 1'b0;
    checkOutput("heldAccepts", accepted, 2);
  endtask

  // Issues an ADD, resets during EXECUTE and checks that nothing retires.
  task automatic applyAbort();
    int writes = 0;
    waitReady();
    bus.instr_valid = 1'b1;
    bus.instr       = enc(3, 6, 1, 2);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    if (bus.reg_write) writes++;
    @(negedge clk);
    if (bus.reg_write) writes++;
    rst = 1'b1;
    @(negedge clk);
    if (bus.reg_write) writes++;
    checkOutput("abortNoWrite", writes, 0);
    checkOutput("abortReadyInRst", int'(bus.instr_ready), 0);
    checkOutput("abortRdPtr", int'(bus.rd_ptr), 0);
    checkOutput("abortWbData", int'(bus.wb_data), 0);
    checkOutput("abortIllegal", int'(bus.illegal), 0);
    rst = 1'b0;
    zModel = 1'b0;
    cModel = 1'b0;
    @(negedge clk);
    checkOutput("abortReady", int'(bus.instr_ready), 1);
    checkOutput("abortBusy", int'(bus.busy), 0);
    checkOutput("abortFlagZ", int'(bus.flag_z), 0);
    checkOutput("abortFlagC", int'(bus.flag_c), 0);
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    for (int i = 0; i < 8; i++) begin
      rf[i]       = 8'h00;
      regModel[i] = 0;
    end

    repeat (3) @(negedge clk);
    checkOutput("readyDuringRst", int'(bus.instr_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstReady", int'(bus.instr_ready), 1);
    checkOutput("rstBusy", int'(bus.busy), 0);
    checkOutput("rstRegWrite", int'(bus.reg_write), 0);
    checkOutput("rstRdPtr", int'(bus.rd_ptr), 0);
    checkOutput("rstWbData", int'(bus.wb_data), 0);
    checkOutput("rstRs1Ptr", int'(bus.rs1_ptr), 0);
    checkOutput("rstRs2Ptr", int'(bus.rs2_ptr), 0);
    checkOutput("rstFlagZ", int'(bus.flag_z), 0);
    checkOutput("rstFlagC", int'(bus.flag_c), 0);
    checkOutput("rstIllegal", int'(bus.illegal), 0);

    applyStimulus(encLdi(3, 8'h5A));
    applyStimulus(encLdi(1, 8'hF0));
    applyStimulus(encLdi(2, 8'h20));
    applyStimulus(enc(3, 4, 1, 2));
    applyStimulus(enc(4, 5, 2, 1));
    applyStimulus(encLdi(1, 8'h77));
    applyStimulus(enc(10, 0, 1, 1));
    applyStimulus(enc(2, 0, 1, 0));
    applyStimulus(16'hC000);
    applyHeld(enc(3, 7, 7, 1));
    applyAbort();
    applyStimulus(encLdi(1, 8'h81));
    applyStimulus(enc(9, 1, 1, 0));
    applyStimulus(enc(8, 2, 1, 0));

    for (int i = 0; i < 40; i++) begin
      logic [15:0] r;
      r = 16'($urandom);
      applyStimulus(r);
    end

    waitReady();
    repeat (2) @(negedge clk);
    checkOutput("scoreboardEmpty", sbQ.size(), 0);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("regFile[%0d]", i), int'(rf[i]), regModel[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sequencer.md
# regfile_sequencer

Write-side and operand-fetch controller for the 8-entry × 8-bit register file of the 8-bit CPU. It accepts one 16-bit instruction at a time over a valid/ready handshake and decodes it. It drives the register file's two combinational read pointers, executes a small internal ALU operation, and issues exactly one write-back (RegWrite / destination pointer / data) per register-writing instruction. It is the sole producer of register-file writes.

## Interface
- No parameters; widths fixed (DATA_W = 8, REG_ADDR_W = 3, INSTR_W = 16 in package).
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- instr_valid  in  1  instruction offered.
- instr  in  16  [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [7:0] imm8 (LDI only).
- instr_ready  out  1  high only in IDLE; transfer when valid&&ready at a clock edge.
- rs1_ptr  out  3  read pointer 1 to register file.
- rs2_ptr  out  3  read pointer 2 to register file.
- rs1_data  in  8  register file combinational read data for rs1_ptr.
- rs2_data  in  8  register file combinational read data for rs2_ptr.
- reg_write  out  1  write strobe to register file, registered.
- rd_ptr  out  3  destination pointer, registered.
- wb_data  out  8  write data, registered.
- flag_z  out  1  zero flag.
- flag_c  out  1  carry/borrow flag.
- illegal  out  1  one-cycle pulse for opcode 11–15.
- busy  out  1  equals !instr_ready.

## Operation
- Opcodes: 0 NOP; 1 LDI rd←imm8; 2 MOV rd←rs1; 3 ADD; 4 SUB; 5 AND; 6 OR; 7 XOR (rd←rs1 op rs2); 8 SHL rd←rs1<<1; 9 SHR rd←rs1>>1 (logical); 10 CMP (rs1−rs2, flags only); 11–15 illegal.
- FSM: IDLE → DECODE → EXECUTE → WRITEBACK → IDLE, unconditional after the handshake; IDLE holds until valid&&ready.
- IDLE: instruction latched into IR on handshake.
- DECODE: rs1_ptr/rs2_ptr = IR fields; rs1_data/rs2_data captured into A/B at the end of the cycle.
- EXECUTE: result and next flags registered.
- WRITEBACK: reg_write=1 for exactly one cycle for opcodes 1–9, with rd_ptr=IR.rd and wb_data=result. For NOP, CMP and illegal, reg_write=0; illegal pulses in this cycle.
- Arithmetic is 8-bit wraparound.
  - ADD: c = carry-out of the 9-bit sum.
  - SUB/CMP: c = borrow (A<B unsigned).
  - SHL: c = A[7]. SHR: c = A[0].
  - AND/OR/XOR: c=0.
- Opcodes 3–10 set z = (8-bit result == 0). Opcodes 0, 1, 2 and illegal leave both flags unchanged.
- rd = any of R0–R7; no hardwired register.
- Hazards: a write retires before the next instruction's DECODE, so no forwarding is needed. rd==rs1 reads the old value.

## Timing
- Reset values: instr_ready=1 (after reset deasserts, state IDLE), reg_write=0, rd_ptr=0, wb_data=0, rs1_ptr=0, rs2_ptr=0, flag_z=0, flag_c=0, illegal=0, busy=0. During rst high, instr_ready=0.
- Latency: handshake at edge N → reg_write high during cycle N+3 → register file updated at edge N+3 → instr_ready high in cycle N+3+1. Throughput: one instruction per 4 cycles.
- instr_valid while busy is ignored; the offering source must hold it.
- rst at any state returns to IDLE next edge. The in-flight instruction is discarded: no write, no flag update, no illegal pulse. rst has priority over a simultaneous handshake.
- rs1_ptr/rs2_ptr are stable throughout DECODE.

## Structure
- Package cpu_pkg holds:
  - opcode localparams (OP_NOP…OP_CMP);
  - state encoding (S_IDLE, S_DECODE, S_EXECUTE, S_WRITEBACK);
  - instruction field bit positions;
  - DATA_W, REG_ADDR_W, INSTR_W.
- One combinational sub-module, alu8: inputs opcode, A, B, imm8; outputs result[7:0], c_out, z_out, flag_update. Sequencer FSM and registers stay in regfile_sequencer.

## Test plan
- Reset, then LDI R3,0x5A → reg_write=1, rd_ptr=3, wb_data=0x5A exactly 3 cycles after handshake. Register file R3=0x5A and instr_ready=1 one cycle later.
- R1=0xF0, R2=0x20, ADD R4,R1,R2 → wb_data=0x10, flag_c=1, flag_z=0. Then SUB R5,R2,R1 → wb_data=0x30, flag_c=1.
- CMP R1,R1 with R1=0x77 → no reg_write, flag_z=1, flag_c=0. Then MOV R0,R1 → R0=0x77, flags unchanged.
- Opcode 0xC → illegal pulses one cycle, reg_write stays 0, flags unchanged. instr_valid held high during busy → only one instruction accepted per 4 cycles.
- ADD issued, rst asserted in EXECUTE → no reg_write, all outputs at reset values, next instruction executes normally.
- Back-to-back LDI R1,0x81; SHR R1,R1; SHL R2,R1 → R1=0x40 (c=1), then R2=0x80 (c=0), confirming read-after-write with no hazard.
